// File: rtl/uart_tx_fifo_ctrl.sv
// rtl/uart_tx_fifo_ctrl.sv - UART TX buffer FIFO with level, thresholds, sticky errors, flush and FWFT/registered read
module uart_tx_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 1,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [CNT_W-1:0]      level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    // Low pointer bits address memory; the extra MSB is the wrap bit.
    localparam int              AW       = CNT_W - 1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LVL_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] LVL_AE   = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_wr_err;
    logic                  w_rd_err;
    logic [DATA_WIDTH-1:0] w_head;

    // Status is decoded from the registered level, so it reflects post-edge state.
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);

    // Flush takes priority: requests in a flush cycle are neither accepted nor flagged.
    // A write into a full FIFO is rejected even if a read pops in the same cycle.
    assign w_wr_acc = wr_en && !w_full  && !flush;
    assign w_rd_acc = rd_en && !w_empty && !flush;
    assign w_wr_err = wr_en &&  w_full  && !flush;
    assign w_rd_err = rd_en &&  w_empty && !flush;

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves level unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ONE;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_level <= r_level + ONE;
            end else if (!w_wr_acc && w_rd_acc) begin
                r_level <= r_level - ONE;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_err) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_rd_err) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally whenever data is stored.
            assign rd_data  = w_empty ? '0 : w_head;
            assign rd_valid = !w_empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            // Registered read: one-cycle valid pulse after each accepted pop, data holds otherwise.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= w_head;
                    end
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign level        = r_level;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= LVL_AF);
    assign almost_empty = (r_level <= LVL_AE);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // The occupancy counter must always track the pointer distance and never exceed DEPTH.
    a_level_tracks_ptrs : assert property (@(posedge clk) disable iff (!rstn)
        (r_level == CNT_W'(r_wr_ptr - r_rd_ptr)) && (r_level <= LVL_FULL));

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb/tb_uart_tx_fifo_ctrl.sv - randomized self-checking bench for uart_tx_fifo_ctrl against a queue model
module tb_uart_tx_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk     = 1'b0;
    logic          rstn    = 1'b0;
    logic          flush   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en   = 1'b0;
    logic          clr_err = 1'b0;

    logic [DW-1:0] d1_rd_data, d0_rd_data;
    logic          d1_rd_valid, d0_rd_valid;
    logic [CW-1:0] d1_level, d0_level;
    logic          d1_full, d0_full, d1_empty, d0_empty;
    logic          d1_af, d0_af, d1_ae, d0_ae;
    logic          d1_ovf, d0_ovf, d1_udf, d0_udf;

    always #5 clk = ~clk;

    uart_tx_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rstn(rstn), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(d1_rd_data), .rd_valid(d1_rd_valid), .level(d1_level), .full(d1_full), .empty(d1_empty),
        .almost_full(d1_af), .almost_empty(d1_ae), .overflow(d1_ovf), .underflow(d1_udf), .clr_err(clr_err)
    );

    uart_tx_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_dut_reg (
        .clk(clk), .rstn(rstn), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(d0_rd_data), .rd_valid(d0_rd_valid), .level(d0_level), .full(d0_full), .empty(d0_empty),
        .almost_full(d0_af), .almost_empty(d0_ae), .overflow(d0_ovf), .underflow(d0_udf), .clr_err(clr_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a plain queue of stored words plus error flags and registered-read state.
    int q[$];
    bit m_ovf;
    bit m_udf;
    bit m_v0;
    int m_d0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_v0  = 0;
        m_d0  = 0;
    endtask

    task automatic model_edge();
        bit was_full;
        bit was_empty;
        bit ovf_evt;
        bit udf_evt;
        ovf_evt = 0;
        udf_evt = 0;
        if (flush) begin
            q.delete();
            m_v0 = 0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            ovf_evt   = wr_en && was_full;
            udf_evt   = rd_en && was_empty;
            if (rd_en && !was_empty) begin
                m_d0 = q.pop_front();
                m_v0 = 1;
            end else begin
                m_v0 = 0;
            end
            if (wr_en && !was_full) q.push_back(int'(wr_data));
        end
        if (ovf_evt) m_ovf = 1; else if (clr_err) m_ovf = 0;
        if (udf_evt) m_udf = 1; else if (clr_err) m_udf = 0;
    endtask

    task automatic check_all();
        int lvl;
        lvl = q.size();
        check("level_fwft", d1_level, lvl);
        check("level_reg", d0_level, lvl);
        check("full", d1_full, lvl == DEPTH);
        check("full_reg", d0_full, lvl == DEPTH);
        check("empty", d1_empty, lvl == 0);
        check("empty_reg", d0_empty, lvl == 0);
        check("almost_full", d1_af, lvl >= AF);
        check("almost_empty", d1_ae, lvl <= AE);
        check("almost_full_reg", d0_af, lvl >= AF);
        check("almost_empty_reg", d0_ae, lvl <= AE);
        check("overflow", d1_ovf, m_ovf);
        check("underflow", d1_udf, m_udf);
        check("overflow_reg", d0_ovf, m_ovf);
        check("underflow_reg", d0_udf, m_udf);
        check("rd_valid_fwft", d1_rd_valid, lvl != 0);
        if (lvl != 0) check("rd_data_fwft", d1_rd_data, q[0]);
        check("rd_valid_reg", d0_rd_valid, m_v0);
        check("rd_data_reg", d0_rd_data, m_d0);
    endtask

    // One clock: inputs are already stable; model follows the edge, outputs sampled 1 time unit later.
    task automatic cyc(input bit we, input int wd, input bit re, input bit fl = 0, input bit ce = 0);
        wr_en   = we;
        wr_data = DW'(wd);
        rd_en   = re;
        flush   = fl;
        clr_err = ce;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        wr_en   = 0;
        rd_en   = 0;
        flush   = 0;
        clr_err = 0;
    endtask

    initial begin
        int pw;
        int pr;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rd_data_fwft_rst", d1_rd_data, 0);
        rstn = 1;

        // Fill to full, then one dropped write
        for (int i = 0; i < 15; i++) cyc(1, 8'h11 + i, 0);
        cyc(1, 8'h20, 0);
        cyc(1, 8'h21, 0);

        // Drain in order, one extra pop, then clear errors
        for (int i = 0; i < 16; i++) cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Single word through the registered read path
        cyc(1, 8'hA5, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);

        // Steady state at level 5 across several pointer wraps
        for (int i = 0; i < 5; i++) cyc(1, 8'h30 + i, 0);
        for (int i = 0; i < 40; i++) cyc(1, 8'h40 + i, 1);

        // Overflow, drain to 9, then flush with both requests active
        for (int i = 0; i < 11; i++) cyc(1, 8'h80 + i, 0);
        cyc(1, 8'hEE, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1);
        cyc(1, 8'h55, 1, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 1);

        // Asynchronous reset mid-stream at level 7
        for (int i = 0; i < 7; i++) cyc(1, 8'hC0 + i, 0);
        rstn = 0;
        #2;
        model_reset();
        check_all();
        check("rd_data_fwft_async_rst", d1_rd_data, 0);
        @(posedge clk);
        #1;
        rstn = 1;
        cyc(1, 8'h5A, 1);
        cyc(0, 0, 1);

        // Randomized traffic with phase-varying write/read bias
        for (int blk = 0; blk < 16; blk++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int i = 0; i < 40; i++) begin
                cyc(($urandom_range(0, 99) < pw), $urandom_range(0, 255),
                    ($urandom_range(0, 99) < pr),
                    ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
# uart_tx_fifo_ctrl

Parametrised transmit buffer for the UART TX path, sitting between the register/bus write side and the TX serialiser. It stores DEPTH words of DATA_WIDTH bits. It provides an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. A FWFT parameter selects first-word-fall-through or registered-read mode.

## Interface
- DATA_WIDTH, 8, width of each stored word
- DEPTH, 16, number of entries; power of two, >= 2; all DEPTH entries usable
- AF_LEVEL, 12, almost_full asserts when level >= AF_LEVEL; range 1..DEPTH
- AE_LEVEL, 4, almost_empty asserts when level <= AE_LEVEL; range 0..DEPTH-1
- FWFT, 1, 1 = first-word-fall-through read, 0 = registered read with one-cycle latency
- CNT_W, $clog2(DEPTH)+1, width of level (derived, not overridden)

- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of contents
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read/pop request
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data valid
- level  out  CNT_W  current number of stored words
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow and underflow

## Operation
- Storage: DEPTH x DATA_WIDTH array. wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit. The low bits index memory and wrap naturally from DEPTH-1 to 0.
- level is a registered counter. It always equals wr_ptr - rd_ptr modulo 2*DEPTH.
- Write accept: wr_en && !full, with full evaluated on the pre-edge state. An accepted write stores wr_data at wr_ptr and increments wr_ptr.
- Rejected write (wr_en && full): data is dropped, no pointer change, overflow is set.
- Read accept: rd_en && !empty. An accepted read increments rd_ptr.
- Rejected read (rd_en && empty): no change, underflow is set.
- Simultaneous accepted write and read: both pointers advance and level is unchanged.
- A write into a full FIFO is rejected even when a read occurs in the same cycle (no pass-through).
- FWFT=1: rd_data = memory[rd_ptr] whenever !empty, and rd_valid = !empty. rd_en acknowledges the current word; the next word appears the cycle after the pop.
- FWFT=0: on an accepted read, rd_data is registered from memory[rd_ptr] and rd_valid pulses high for exactly one cycle, the cycle after rd_en. Otherwise rd_data holds its last value and rd_valid = 0.
- flush: at the edge it is sampled, wr_ptr, rd_ptr and level go to 0. flush overrides any wr_en/rd_en in the same cycle, and those requests set no error flags. rd_valid clears. Sticky flags are not cleared by flush.
- clr_err clears both sticky flags. If an error event occurs in the same cycle as clr_err, the flag is set (set wins).
- Status flags: full, empty, almost_full and almost_empty are decoded from registered level. They reflect the post-edge state.

## Timing
- Reset (rstn low, asynchronous):
  - pointers = 0, level = 0
  - empty = 1, full = 0, almost_full = 0, almost_empty = 1
  - rd_data = 0, rd_valid = 0
  - overflow = 0, underflow = 0
- Memory contents are not reset.
- Write-to-visible latency:
  - level, empty and flags update 1 cycle after the write edge.
  - FWFT=1: the written word appears on rd_data in the same cycle empty deasserts.
- Read latency: FWFT=1 gives 0 cycles (data present before rd_en); FWFT=0 gives 1 cycle from rd_en to rd_valid/rd_data.
- Back-to-back: one write and one read per cycle sustained, no bubbles, including across pointer wrap.
- Reset asserted mid-operation: all state returns to reset values immediately. After rstn deasserts, the first edge behaves as from empty.

## Test plan
- Reset, then write 0x11..0x1F (15 words, DEPTH=16) -> level=15, almost_full=1 at level 12, full=0; write 0x20 -> full=1, level=16; write 0x21 -> dropped, overflow=1, level stays 16.
- From full, read 16 words (FWFT=1) -> rd_data sequence 0x11..0x20 in order; empty=1 after the last pop; one extra rd_en -> underflow=1; clr_err -> both flags 0.
- FWFT=0: write 0xA5, then rd_en one cycle -> rd_valid high exactly one cycle later with rd_data=0xA5; level goes 1->0.
- Simultaneous wr_en+rd_en at level 5, 40 cycles with incrementing data -> level constant at 5, pointers wrap at least twice, output order matches input order.
- At level 9, assert flush with wr_en and rd_en high -> next cycle level=0, empty=1, no error flags set; a prior overflow=1 stays set.
- Assert rstn low for one cycle mid-stream at level 7 -> level=0, empty=1, rd_valid=0, overflow=underflow=0 immediately, before the next clk edge.
